// File: rtl/ifu_fetch_if.sv
// Bundle of the fetch stage's memory read bus, decode handshake and writeback PC path.
// The master modport is the fetch unit; the slave modport is everything around it.
interface ifu_fetch_if;
    logic        mem_arvalid;
    logic [31:0] mem_araddr;
    logic        mem_arready;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic [1:0]  mem_rresp;
    logic        mem_rready;
    logic        ifu_valid;
    logic [63:0] ifu_data;
    logic        idu_ready;
    logic        pc_wen;
    logic [31:0] pc_next;
    logic        ifu_fault;
    logic [31:0] fetch_count;

    modport master (
        output mem_arvalid,
        output mem_araddr,
        input  mem_arready,
        input  mem_rvalid,
        input  mem_rdata,
        input  mem_rresp,
        output mem_rready,
        output ifu_valid,
        output ifu_data,
        input  idu_ready,
        input  pc_wen,
        input  pc_next,
        output ifu_fault,
        output fetch_count
    );

    modport slave (
        input  mem_arvalid,
        input  mem_araddr,
        output mem_arready,
        output mem_rvalid,
        output mem_rdata,
        output mem_rresp,
        input  mem_rready,
        input  ifu_valid,
        input  ifu_data,
        output idu_ready,
        output pc_wen,
        output pc_next,
        input  ifu_fault,
        input  fetch_count
    );
endinterface

// File: rtl/ifu_fetch.sv
// Instruction fetch stage: one bus read per instruction, hands {inst, pc} to decode,
// then waits for writeback to supply the next PC.
module ifu_fetch #(
    parameter logic [31:0] RESET_PC       = 32'h8000_0000,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    ifu_fetch_if.master bus
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_FETCH   = 3'd1;
    localparam logic [2:0] S_RESP    = 3'd2;
    localparam logic [2:0] S_HOLD    = 3'd3;
    localparam logic [2:0] S_WAIT_PC = 3'd4;

    localparam bit          TIMEOUT_EN   = (TIMEOUT_CYCLES != 0);
    localparam logic [31:0] TIMEOUT_LAST = TIMEOUT_EN ? 32'(TIMEOUT_CYCLES - 32'd1) : 32'd0;

    logic [2:0]  state;
    logic [2:0]  state_nxt;
    logic [31:0] pc;
    logic [31:0] pc_nxt;
    logic [31:0] inst;
    logic [31:0] inst_nxt;
    logic [31:0] tcnt;
    logic [31:0] tcnt_nxt;
    logic [31:0] count_q;
    logic [31:0] count_nxt;
    logic        fault_q;
    logic        fault_nxt;

    logic rsp_ok;
    logic timed_out;

    assign rsp_ok    = (bus.mem_rresp == 2'b00);
    assign timed_out = TIMEOUT_EN && (tcnt == TIMEOUT_LAST);

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        inst_nxt  = inst;
        tcnt_nxt  = tcnt;
        count_nxt = count_q;
        fault_nxt = 1'b0;

        case (state)
            S_IDLE: begin
                state_nxt = S_FETCH;
            end

            S_FETCH: begin
                if (bus.mem_arready) begin
                    state_nxt = S_RESP;
                    tcnt_nxt  = '0;
                end
            end

            S_RESP: begin
                // A response arriving in the last allowed cycle still counts.
                if (bus.mem_rvalid) begin
                    if (rsp_ok) begin
                        inst_nxt  = bus.mem_rdata;
                        state_nxt = S_HOLD;
                    end else begin
                        fault_nxt = 1'b1;
                        state_nxt = S_WAIT_PC;
                    end
                end else if (timed_out) begin
                    fault_nxt = 1'b1;
                    state_nxt = S_WAIT_PC;
                end else begin
                    tcnt_nxt = tcnt + 32'd1;
                end
            end

            S_HOLD: begin
                if (bus.idu_ready) begin
                    count_nxt = count_q + 32'd1;
                    state_nxt = S_WAIT_PC;
                end
            end

            S_WAIT_PC: begin
                if (bus.pc_wen) begin
                    if (bus.pc_next[1:0] == 2'b00) begin
                        pc_nxt    = bus.pc_next;
                        state_nxt = S_FETCH;
                    end else begin
                        fault_nxt = 1'b1;
                    end
                end
            end

            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            pc      <= RESET_PC;
            inst    <= '0;
            tcnt    <= '0;
            count_q <= '0;
            fault_q <= 1'b0;
        end else begin
            state   <= state_nxt;
            pc      <= pc_nxt;
            inst    <= inst_nxt;
            tcnt    <= tcnt_nxt;
            count_q <= count_nxt;
            fault_q <= fault_nxt;
        end
    end

    // Handshake outputs come straight from the state so an async reset drops them at once.
    assign bus.mem_arvalid = (state == S_FETCH);
    assign bus.mem_araddr  = pc;
    assign bus.mem_rready  = (state == S_RESP);
    assign bus.ifu_valid   = (state == S_HOLD);
    assign bus.ifu_data    = (state == S_HOLD) ? {inst, pc} : 64'd0;
    assign bus.ifu_fault   = fault_q;
    assign bus.fetch_count = count_q;

    a_single_phase: assert property (@(posedge clk) disable iff (rst)
        $onehot0({bus.mem_arvalid, bus.mem_rready, bus.ifu_valid}));

    a_hold_stable: assert property (@(posedge clk) disable iff (rst)
        (bus.ifu_valid && !bus.idu_ready) |=> (bus.ifu_valid && $stable(bus.ifu_data)));

endmodule

// File: tb/tb_ifu_fetch.sv
// Randomised bench for ifu_fetch: a driver plays memory, decode and writeback while a
// monitor pops expected addresses, instructions and counts from scoreboard queues.
module tb_ifu_fetch;
    localparam logic [31:0] RESET_PC = 32'h8000_0000;
    localparam int          TO       = 4;
    localparam int          K_OK     = 0;
    localparam int          K_ERR    = 1;
    localparam int          K_TMO    = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;

    ifu_fetch_if bus();

    ifu_fetch #(.RESET_PC(RESET_PC), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [63:0] exp_q[$];
    logic [31:0] addr_q[$];
    int          exp_faults  = 0;
    int          obs_faults  = 0;
    logic [31:0] model_cnt   = 32'd0;
    logic        cnt_pending = 1'b0;
    logic        fault_prev  = 1'b0;
    logic [31:0] model_pc    = RESET_PC;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: everything it compares against comes from the scoreboard queues.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (cnt_pending) begin
                    check("fetch_count", 64'(bus.fetch_count), 64'(model_cnt));
                    cnt_pending = 1'b0;
                end
                if (bus.mem_arvalid && bus.mem_arready) begin
                    if (addr_q.size() == 0) begin
                        check("unexpected_ar", 64'(bus.mem_araddr), 64'hFFFF_FFFF_FFFF_FFFF);
                    end else begin
                        check("araddr", 64'(bus.mem_araddr), 64'(addr_q.pop_front()));
                    end
                end
                if (bus.ifu_valid) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_valid", 64'(bus.ifu_valid), 64'd0);
                    end else begin
                        check("ifu_data", bus.ifu_data, exp_q[0]);
                        if (bus.idu_ready) begin
                            void'(exp_q.pop_front());
                            model_cnt   = model_cnt + 32'd1;
                            cnt_pending = 1'b1;
                        end
                    end
                end
                if (bus.ifu_fault) begin
                    obs_faults++;
                    check("fault_pulse_width", 64'(fault_prev), 64'd0);
                end
                fault_prev = bus.ifu_fault;
            end else begin
                fault_prev = 1'b0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic wait_ar(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (bus.mem_arvalid) begin
                ok = 1'b1;
                return;
            end
            step();
        end
        check("ar_wait_bound", 64'd0, 64'd1);
    endtask

    task automatic do_fetch(input int kind, input int war, input int wr, input int widu,
                            input logic [31:0] rd);
        bit ok;
        addr_q.push_back(model_pc);
        wait_ar(ok);
        if (!ok) begin
            addr_q.delete();
            return;
        end
        repeat (war) step();
        bus.mem_arready = 1'b1;
        step();
        bus.mem_arready = 1'b0;

        if (kind == K_OK) begin
            repeat (wr) step();
            bus.mem_rvalid = 1'b1;
            bus.mem_rdata  = rd;
            bus.mem_rresp  = 2'b00;
            exp_q.push_back({rd, model_pc});
            step();
            bus.mem_rvalid = 1'b0;
            bus.mem_rdata  = $urandom;
            check("valid_latency", 64'(bus.ifu_valid), 64'd1);
            for (int i = 0; i < widu; i++) begin
                logic [31:0] r;
                r = $urandom;
                bus.pc_wen  = 1'($urandom_range(0, 1));
                bus.pc_next = {r[31:2], 2'b00};
                step();
            end
            bus.pc_wen    = 1'b0;
            bus.idu_ready = 1'b1;
            step();
            bus.idu_ready = 1'b0;
            check("valid_drop", 64'(bus.ifu_valid), 64'd0);
        end else if (kind == K_ERR) begin
            repeat (wr) step();
            bus.mem_rvalid = 1'b1;
            bus.mem_rresp  = 2'($urandom_range(1, 3));
            bus.mem_rdata  = $urandom;
            exp_faults++;
            step();
            bus.mem_rvalid = 1'b0;
            bus.mem_rresp  = 2'b00;
            check("err_fault", 64'(bus.ifu_fault), 64'd1);
            check("err_no_valid", 64'(bus.ifu_valid), 64'd0);
        end else begin
            repeat (TO - 1) step();
            check("timeout_early", 64'(bus.ifu_fault), 64'd0);
            step();
            exp_faults++;
            check("timeout_fault", 64'(bus.ifu_fault), 64'd1);
            bus.mem_rvalid = 1'b1;
            bus.mem_rresp  = 2'b00;
            bus.mem_rdata  = $urandom;
            step();
            step();
            bus.mem_rvalid = 1'b0;
            check("late_rvalid_ignored", 64'(bus.ifu_valid), 64'd0);
        end
    endtask

    // Supplies nmis misaligned PCs (each must fault) and then the aligned target.
    task automatic set_pc(input int nmis, input int mis_off, input logic [31:0] target);
        step();
        for (int i = 0; i < nmis; i++) begin
            int off;
            off = (mis_off != 0) ? mis_off : int'($urandom_range(1, 3));
            bus.pc_wen  = 1'b1;
            bus.pc_next = target - 32'(off);
            exp_faults++;
            step();
            bus.pc_wen = 1'b0;
            check("misaligned_fault", 64'(bus.ifu_fault), 64'd1);
            check("misaligned_no_fetch", 64'(bus.mem_arvalid), 64'd0);
            step();
        end
        bus.pc_wen  = 1'b1;
        bus.pc_next = target;
        model_pc    = target;
        step();
        bus.pc_wen = 1'b0;
        check("pc_to_fetch_latency", 64'(bus.mem_arvalid), 64'd1);
        check("fault_count", 64'(obs_faults), 64'(exp_faults));
    endtask

    initial begin
        bit ok;
        bus.mem_arready = 1'b0;
        bus.mem_rvalid  = 1'b0;
        bus.mem_rdata   = '0;
        bus.mem_rresp   = 2'b00;
        bus.idu_ready   = 1'b0;
        bus.pc_wen      = 1'b0;
        bus.pc_next     = '0;

        repeat (2) step();
        check("rst_arvalid", 64'(bus.mem_arvalid), 64'd0);
        check("rst_rready", 64'(bus.mem_rready), 64'd0);
        check("rst_ifu_valid", 64'(bus.ifu_valid), 64'd0);
        check("rst_ifu_data", bus.ifu_data, 64'd0);
        check("rst_fault", 64'(bus.ifu_fault), 64'd0);
        check("rst_count", 64'(bus.fetch_count), 64'd0);
        check("rst_araddr", 64'(bus.mem_araddr), 64'(RESET_PC));
        rst = 1'b0;

        do_fetch(K_OK, 0, 0, 0, 32'h0000_0513);
        set_pc(0, 0, 32'h8000_0004);
        do_fetch(K_OK, 0, 1, 5, 32'hDEAD_BEEF);
        set_pc(0, 0, 32'h8000_0008);
        do_fetch(K_ERR, 1, 0, 0, 32'h0);
        set_pc(0, 0, 32'h8000_0004);
        do_fetch(K_OK, 0, 0, 0, 32'h0010_0093);
        set_pc(1, 2, 32'h8000_0008);
        do_fetch(K_TMO, 0, 0, 0, 32'h0);
        set_pc(0, 0, 32'h8000_000C);
        do_fetch(K_OK, 2, TO - 1, 1, 32'h1234_5678);
        set_pc(0, 0, 32'h8000_0010);

        // Async reset while waiting for a response.
        addr_q.push_back(model_pc);
        wait_ar(ok);
        bus.mem_arready = 1'b1;
        step();
        bus.mem_arready = 1'b0;
        check("pre_rst_in_resp", 64'(bus.mem_rready), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_arvalid", 64'(bus.mem_arvalid), 64'd0);
        check("midrst_rready", 64'(bus.mem_rready), 64'd0);
        check("midrst_ifu_valid", 64'(bus.ifu_valid), 64'd0);
        check("midrst_count", 64'(bus.fetch_count), 64'd0);
        check("midrst_araddr", 64'(bus.mem_araddr), 64'(RESET_PC));
        model_cnt   = 32'd0;
        cnt_pending = 1'b0;
        model_pc    = RESET_PC;
        exp_q.delete();
        addr_q.delete();
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'hBAD0_BAD0;
        repeat (2) step();
        bus.mem_rvalid = 1'b0;
        rst = 1'b0;
        do_fetch(K_OK, 0, 0, 0, 32'h0000_0513);
        set_pc(0, 0, 32'h8000_0004);

        for (int n = 0; n < 40; n++) begin
            int          sel;
            int          kind;
            logic [31:0] r;
            logic [31:0] tgt;
            sel  = int'($urandom_range(0, 99));
            kind = (sel < 70) ? K_OK : ((sel < 85) ? K_ERR : K_TMO);
            do_fetch(kind, int'($urandom_range(0, 2)), int'($urandom_range(0, TO - 1)),
                     int'($urandom_range(0, 3)), $urandom);
            r   = $urandom;
            tgt = ($urandom_range(0, 3) == 0) ? {r[31:2], 2'b00} : model_pc + 32'd4;
            set_pc(int'($urandom_range(0, 1)), 0, tgt);
        end

        repeat (3) step();
        check("final_exp_q_empty", 64'(exp_q.size()), 64'd0);
        check("final_addr_q_empty", 64'(addr_q.size()), 64'd0);
        check("final_fault_count", 64'(obs_faults), 64'(exp_faults));
        check("final_fetch_count", 64'(bus.fetch_count), 64'(model_cnt));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
